// File: rtl/rr_grant_arbiter_if.sv
// Requester/resource handshake bundle for the round-robin grant arbiter.
// The master side drives requests and done; the slave side (arbiter) drives the grant.
interface rr_grant_arbiter_if #(
  parameter int N = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic          timeout_err;

  modport master (
    output req, done,
    input  gnt, gnt_id, busy, timeout_err
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, busy, timeout_err
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for one single-owner resource: registered one-hot grant held
// until done or watchdog timeout, followed by one dead cycle before re-arbitration.
module rr_grant_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_grant_arbiter_if.slave  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, REL = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;

  logic          win_found;
  logic [IW-1:0] win_id;
  int            idx;
  logic          cnt_at_max;
  logic          release_now;
  logic [IW-1:0] ptr_after;

  assign cnt_at_max  = (cnt_q == CW'(TIMEOUT - 1));
  assign release_now = bus.done || cnt_at_max;
  assign ptr_after   = (gnt_id_q == IW'(N - 1)) ? '0 : gnt_id_q + IW'(1);

  // First set request scanning upward from ptr_q, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = BUSY;
      BUSY:    if (release_now) state_d = REL;
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    terr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d         = '0;
          gnt_d[win_id] = 1'b1;
          gnt_id_d      = win_id;
          cnt_d         = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          gnt_d  = '0;
          ptr_d  = ptr_after;
          // done on the last allowed cycle is a clean release, not a timeout
          terr_d = !bus.done;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        gnt_d = '0;
      end
    endcase
  end

  assign bus.gnt         = gnt_q;
  assign bus.gnt_id      = gnt_id_q;
  assign bus.busy        = (state_q == BUSY);
  assign bus.timeout_err = terr_q;
endmodule
